// File: rtl/svc_axil_pkg.sv
// svc_axil_pkg
//   Shared AXI-Lite constants for the svc_axil_* fabric blocks.
//   Contents: the three BRESP/RRESP codes the routers generate or forward.
package svc_axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/svc_axil_router_wr_chk.sv
// svc_axil_router_wr_chk
//   Property checker for svc_axil_router_wr, instantiated inside the router.
// Ports
//   clk, rst             clock, synchronous active-high reset
//   in_issue             router FSM is in ISSUE
//   m_awvalid, m_wvalid  per-subordinate request valids
module svc_axil_router_wr_chk #(
   parameter int NUM_S = 2
) (
   input logic             clk,
   input logic             rst,
   input logic             in_issue,
   input logic [NUM_S-1:0] m_awvalid,
   input logic [NUM_S-1:0] m_wvalid
);

   // A subordinate is only ever driven while a write is being issued
   a_valid_in_issue : assert property (@(posedge clk) disable iff (rst)
      ((|m_awvalid) || (|m_wvalid)) |-> in_issue);

   // Never address two subordinates at once
   a_aw_onehot : assert property (@(posedge clk) disable iff (rst)
      $onehot0(m_awvalid));

endmodule

// File: rtl/svc_skidbuf.sv
// svc_skidbuf
//   Two-entry ready/valid skid buffer. in_ready is a pure register output,
//   which breaks the combinational ready path from the consumer.
//   OPT_OUTREG=0: an empty buffer passes in_* straight to out_*, with zero
//                 latency; the skid register only catches a beat that the
//                 consumer refused.
//   OPT_OUTREG=1: out_valid/out_data come from a register. Each beat appears
//                 on the output one cycle after it is accepted.
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake, in_data payload
//   out_valid/out_ready downstream handshake, out_data payload
module svc_skidbuf #(
   parameter int DW         = 8,
   parameter bit OPT_OUTREG = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
);

   logic          skid_valid_r;
   logic [DW-1:0] skid_data_r;

   assign in_ready = ~skid_valid_r;

   generate
      if (OPT_OUTREG) begin : g_outreg
         logic          out_valid_r;
         logic [DW-1:0] out_data_r;

         // Output register refills whenever it is empty or being drained; otherwise park the new beat in the skid slot
         always_ff @(posedge clk) begin
            if (rst) begin
               out_valid_r  <= 1'b0;
               out_data_r   <= {DW{1'b0}};
               skid_valid_r <= 1'b0;
               skid_data_r  <= {DW{1'b0}};
            end else if (!out_valid_r || out_ready) begin
               out_valid_r  <= in_valid || skid_valid_r;
               out_data_r   <= skid_valid_r ? skid_data_r : in_data;
               skid_valid_r <= 1'b0;
            end else if (in_valid && !skid_valid_r) begin
               skid_valid_r <= 1'b1;
               skid_data_r  <= in_data;
            end
         end

         assign out_valid = out_valid_r;
         assign out_data  = out_data_r;
      end else begin : g_pass
         assign out_valid = in_valid || skid_valid_r;
         assign out_data  = skid_valid_r ? skid_data_r : in_data;

         // Catch a beat the consumer refused; release it once the consumer takes it
         always_ff @(posedge clk) begin
            if (rst) begin
               skid_valid_r <= 1'b0;
               skid_data_r  <= {DW{1'b0}};
            end else if (skid_valid_r) begin
               if (out_ready) begin
                  skid_valid_r <= 1'b0;
               end
            end else if (in_valid && !out_ready) begin
               skid_valid_r <= 1'b1;
               skid_data_r  <= in_data;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/svc_axil_router_wr.sv
// svc_axil_router_wr
//   1:N AXI-Lite write router, one transaction in flight. The top
//   $clog2(NUM_S) address bits select the subordinate; they are zeroed in
//   the forwarded address. A select >= NUM_S is answered locally with DECERR.
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   s_axil_aw*/w*/b*                manager-side AW, W and B channels
//   m_axil_aw*/w*/b* [NUM_S]        per-subordinate AW, W and B channels
module svc_axil_router_wr
   import svc_axil_pkg::*;
#(
   parameter int S_AXIL_ADDR_WIDTH = 32,
   parameter int S_AXIL_DATA_WIDTH = 16,
   parameter int M_AXIL_ADDR_WIDTH = 32,
   parameter int M_AXIL_DATA_WIDTH = 16,
   parameter int NUM_S             = 2
) (
   input  logic                                                 clk,
   input  logic                                                 rst,
   input  logic                                                 s_axil_awvalid,
   output logic                                                 s_axil_awready,
   input  logic [S_AXIL_ADDR_WIDTH-1:0]                         s_axil_awaddr,
   input  logic                                                 s_axil_wvalid,
   output logic                                                 s_axil_wready,
   input  logic [S_AXIL_DATA_WIDTH-1:0]                         s_axil_wdata,
   input  logic [S_AXIL_DATA_WIDTH/8-1:0]                       s_axil_wstrb,
   output logic                                                 s_axil_bvalid,
   input  logic                                                 s_axil_bready,
   output logic [1:0]                                           s_axil_bresp,
   output logic [NUM_S-1:0]                                     m_axil_awvalid,
   input  logic [NUM_S-1:0]                                     m_axil_awready,
   output logic [NUM_S-1:0][M_AXIL_ADDR_WIDTH-1:0]              m_axil_awaddr,
   output logic [NUM_S-1:0]                                     m_axil_wvalid,
   input  logic [NUM_S-1:0]                                     m_axil_wready,
   output logic [NUM_S-1:0][M_AXIL_DATA_WIDTH-1:0]              m_axil_wdata,
   output logic [NUM_S-1:0][M_AXIL_DATA_WIDTH/8-1:0]            m_axil_wstrb,
   input  logic [NUM_S-1:0]                                     m_axil_bvalid,
   output logic [NUM_S-1:0]                                     m_axil_bready,
   input  logic [NUM_S-1:0][1:0]                                m_axil_bresp
);

   localparam int S_AW  = S_AXIL_ADDR_WIDTH;
   localparam int S_DW  = S_AXIL_DATA_WIDTH;
   localparam int S_SW  = S_DW / 8;
   localparam int M_AW  = M_AXIL_ADDR_WIDTH;
   localparam int M_DW  = M_AXIL_DATA_WIDTH;
   localparam int M_SW  = M_DW / 8;
   localparam int SEL_W = $clog2(NUM_S);

   localparam logic [NUM_S-1:0] ONE_S = NUM_S'(1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;
   localparam logic [1:0] ST_ERR   = 2'd3;

   // Buffered manager request channels
   logic                 aw_valid_s;
   logic                 aw_ready_s;
   logic [S_AW-1:0]      aw_addr_s;
   logic                 w_valid_s;
   logic                 w_ready_s;
   logic [S_DW+S_SW-1:0] w_bus_s;

   // Per-subordinate response buffers
   logic [NUM_S-1:0]      b_gate_s;
   logic [NUM_S-1:0]      sb_in_valid_s;
   logic [NUM_S-1:0]      sb_in_ready_s;
   logic [NUM_S-1:0]      sb_out_valid_s;
   logic [NUM_S-1:0]      sb_out_ready_s;
   logic [NUM_S-1:0][1:0] sb_out_data_s;

   // Manager response output stage
   logic       ob_in_valid_s;
   logic       ob_in_ready_s;
   logic [1:0] ob_in_data_s;

   // Control
   logic [1:0]       state_r;
   logic [SEL_W-1:0] sel_r;
   logic [NUM_S-1:0] m_awvalid_r;
   logic [NUM_S-1:0] m_wvalid_r;
   logic [M_AW-1:0]  m_awaddr_r;
   logic [M_DW-1:0]  m_wdata_r;
   logic [M_SW-1:0]  m_wstrb_r;

   logic [SEL_W-1:0] sel_in_s;
   logic             dec_err_s;
   logic [S_AW-1:0]  sub_addr_s;
   logic             b_free_s;
   logic             start_s;
   logic             sel_bvalid_s;
   logic [1:0]       sel_bresp_s;
   logic             resp_take_s;
   logic [NUM_S-1:0] aw_left_s;
   logic [NUM_S-1:0] w_left_s;

   svc_skidbuf #(.DW(S_AW), .OPT_OUTREG(1'b0)) u_aw_buf (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s_axil_awvalid),
      .in_ready  (s_axil_awready),
      .in_data   (s_axil_awaddr),
      .out_valid (aw_valid_s),
      .out_ready (aw_ready_s),
      .out_data  (aw_addr_s)
   );

   svc_skidbuf #(.DW(S_DW + S_SW), .OPT_OUTREG(1'b0)) u_w_buf (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s_axil_wvalid),
      .in_ready  (s_axil_wready),
      .in_data   ({s_axil_wdata, s_axil_wstrb}),
      .out_valid (w_valid_s),
      .out_ready (w_ready_s),
      .out_data  (w_bus_s)
   );

   // Decode the select field and form the subordinate-relative address
   always_comb begin
      sel_in_s   = aw_addr_s[S_AW-1 -: SEL_W];
      dec_err_s  = ({1'b0, sel_in_s} >= (SEL_W + 1)'(NUM_S));
      sub_addr_s = aw_addr_s;
      sub_addr_s[S_AW-1 -: SEL_W] = {SEL_W{1'b0}};
   end

   // A write may start only if its response cannot collide with an unconsumed B
   assign b_free_s   = !s_axil_bvalid || s_axil_bready;
   assign start_s    = (state_r == ST_IDLE) && aw_valid_s && w_valid_s && b_free_s;
   assign aw_ready_s = start_s;
   assign w_ready_s  = start_s;

   // Select the response of the active subordinate
   always_comb begin
      sel_bvalid_s = 1'b0;
      sel_bresp_s  = RESP_OKAY;
      for (int i = 0; i < NUM_S; i++) begin
         sel_bvalid_s = sel_bvalid_s | (sb_out_valid_s[i] & (sel_r == SEL_W'(i)));
         sel_bresp_s  = sel_bresp_s | (sb_out_data_s[i] & {2{sel_r == SEL_W'(i)}});
      end
   end

   assign resp_take_s   = (state_r == ST_RESP) && sel_bvalid_s && ob_in_ready_s;
   assign ob_in_valid_s = resp_take_s || (state_r == ST_ERR);
   assign ob_in_data_s  = (state_r == ST_ERR) ? RESP_DECERR : sel_bresp_s;
   assign aw_left_s     = m_awvalid_r & ~m_axil_awready;
   assign w_left_s      = m_wvalid_r & ~m_axil_wready;

   generate
      for (genvar gi = 0; gi < NUM_S; gi++) begin : g_sub
         // Only the selected subordinate in RESP can hand a response over
         assign b_gate_s[gi]       = (state_r == ST_RESP) && (sel_r == SEL_W'(gi));
         assign sb_in_valid_s[gi]  = m_axil_bvalid[gi] & b_gate_s[gi];
         assign m_axil_bready[gi]  = sb_in_ready_s[gi] & b_gate_s[gi];
         assign sb_out_ready_s[gi] = b_gate_s[gi] & ob_in_ready_s;

         svc_skidbuf #(.DW(2), .OPT_OUTREG(1'b0)) u_b_buf (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (sb_in_valid_s[gi]),
            .in_ready  (sb_in_ready_s[gi]),
            .in_data   (m_axil_bresp[gi]),
            .out_valid (sb_out_valid_s[gi]),
            .out_ready (sb_out_ready_s[gi]),
            .out_data  (sb_out_data_s[gi])
         );

         // Request payload is broadcast; only the valid is per-subordinate
         assign m_axil_awaddr[gi] = m_awaddr_r;
         assign m_axil_wdata[gi]  = m_wdata_r;
         assign m_axil_wstrb[gi]  = m_wstrb_r;
      end
   endgenerate

   assign m_axil_awvalid = m_awvalid_r;
   assign m_axil_wvalid  = m_wvalid_r;

   svc_skidbuf #(.DW(2), .OPT_OUTREG(1'b1)) u_bout_buf (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (ob_in_valid_s),
      .in_ready  (ob_in_ready_s),
      .in_data   (ob_in_data_s),
      .out_valid (s_axil_bvalid),
      .out_ready (s_axil_bready),
      .out_data  (s_axil_bresp)
   );

   // Transaction FSM: latch the request at start, issue, then collect one response
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         sel_r       <= {SEL_W{1'b0}};
         m_awvalid_r <= {NUM_S{1'b0}};
         m_wvalid_r  <= {NUM_S{1'b0}};
         m_awaddr_r  <= {M_AW{1'b0}};
         m_wdata_r   <= {M_DW{1'b0}};
         m_wstrb_r   <= {M_SW{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_s) begin
                  sel_r      <= sel_in_s;
                  m_awaddr_r <= M_AW'(sub_addr_s);
                  m_wdata_r  <= M_DW'(w_bus_s[S_DW+S_SW-1:S_SW]);
                  m_wstrb_r  <= M_SW'(w_bus_s[S_SW-1:0]);
                  if (dec_err_s) begin
                     state_r <= ST_ERR;
                  end else begin
                     state_r     <= ST_ISSUE;
                     m_awvalid_r <= ONE_S << sel_in_s;
                     m_wvalid_r  <= ONE_S << sel_in_s;
                  end
               end
            end
            ST_ISSUE: begin
               m_awvalid_r <= aw_left_s;
               m_wvalid_r  <= w_left_s;
               if ((aw_left_s == {NUM_S{1'b0}}) && (w_left_s == {NUM_S{1'b0}})) begin
                  state_r <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (resp_take_s) begin
                  state_r <= ST_IDLE;
               end
            end
            ST_ERR: begin
               if (ob_in_ready_s) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               m_awvalid_r <= {NUM_S{1'b0}};
               m_wvalid_r  <= {NUM_S{1'b0}};
            end
         endcase
      end
   end

   svc_axil_router_wr_chk #(.NUM_S(NUM_S)) u_chk (
      .clk       (clk),
      .rst       (rst),
      .in_issue  (state_r == ST_ISSUE),
      .m_awvalid (m_awvalid_r),
      .m_wvalid  (m_wvalid_r)
   );

endmodule

// File: tb/tb_svc_axil_router_wr.sv
// tb_svc_axil_router_wr
//   Directed bench for svc_axil_router_wr. dut drives two modelled
//   subordinates (sub0 answers SLVERR, sub1 answers OKAY); dut3 has three
//   subordinates and exercises the DECERR path and the response gating.
module tb_svc_axil_router_wr;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // NUM_S=2 instance
   logic            s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic [31:0]     s_awaddr;
   logic [15:0]     s_wdata;
   logic [1:0]      s_wstrb, s_bresp;
   logic [1:0]      m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic [1:0][31:0] m_awaddr;
   logic [1:0][15:0] m_wdata;
   logic [1:0][1:0]  m_wstrb, m_bresp;

   // NUM_S=3 instance
   logic            c_awvalid, c_awready, c_wvalid, c_wready, c_bvalid, c_bready;
   logic [31:0]     c_awaddr;
   logic [15:0]     c_wdata;
   logic [1:0]      c_wstrb, c_bresp;
   logic [2:0]      c_m_awvalid, c_m_awready, c_m_wvalid, c_m_wready, c_m_bvalid, c_m_bready;
   logic [2:0][31:0] c_m_awaddr;
   logic [2:0][15:0] c_m_wdata;
   logic [2:0][1:0]  c_m_wstrb, c_m_bresp;

   svc_axil_router_wr #(.NUM_S(2)) dut (
      .clk(clk), .rst(rst),
      .s_axil_awvalid(s_awvalid), .s_axil_awready(s_awready), .s_axil_awaddr(s_awaddr),
      .s_axil_wvalid(s_wvalid), .s_axil_wready(s_wready), .s_axil_wdata(s_wdata),
      .s_axil_wstrb(s_wstrb), .s_axil_bvalid(s_bvalid), .s_axil_bready(s_bready),
      .s_axil_bresp(s_bresp),
      .m_axil_awvalid(m_awvalid), .m_axil_awready(m_awready), .m_axil_awaddr(m_awaddr),
      .m_axil_wvalid(m_wvalid), .m_axil_wready(m_wready), .m_axil_wdata(m_wdata),
      .m_axil_wstrb(m_wstrb), .m_axil_bvalid(m_bvalid), .m_axil_bready(m_bready),
      .m_axil_bresp(m_bresp)
   );

   svc_axil_router_wr #(.NUM_S(3)) dut3 (
      .clk(clk), .rst(rst),
      .s_axil_awvalid(c_awvalid), .s_axil_awready(c_awready), .s_axil_awaddr(c_awaddr),
      .s_axil_wvalid(c_wvalid), .s_axil_wready(c_wready), .s_axil_wdata(c_wdata),
      .s_axil_wstrb(c_wstrb), .s_axil_bvalid(c_bvalid), .s_axil_bready(c_bready),
      .s_axil_bresp(c_bresp),
      .m_axil_awvalid(c_m_awvalid), .m_axil_awready(c_m_awready), .m_axil_awaddr(c_m_awaddr),
      .m_axil_wvalid(c_m_wvalid), .m_axil_wready(c_m_wready), .m_axil_wdata(c_m_wdata),
      .m_axil_wstrb(c_m_wstrb), .m_axil_bvalid(c_m_bvalid), .m_axil_bready(c_m_bready),
      .m_axil_bresp(c_m_bresp)
   );

   // Subordinate model for dut: raise bvalid once both AW and W have been taken
   logic [1:0] aw_seen, w_seen;
   logic       b_en;
   int         b_cnt = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_bvalid <= 2'b00;
         aw_seen  <= 2'b00;
         w_seen   <= 2'b00;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (m_bvalid[i]) begin
               if (m_bready[i]) m_bvalid[i] <= 1'b0;
            end else if (b_en && (aw_seen[i] || (m_awvalid[i] && m_awready[i]))
                              && (w_seen[i] || (m_wvalid[i] && m_wready[i]))) begin
               m_bvalid[i] <= 1'b1;
               aw_seen[i]  <= 1'b0;
               w_seen[i]   <= 1'b0;
            end else begin
               if (m_awvalid[i] && m_awready[i]) aw_seen[i] <= 1'b1;
               if (m_wvalid[i] && m_wready[i])   w_seen[i]  <= 1'b1;
            end
         end
      end
   end

   // Count completed manager-side responses of dut
   always @(posedge clk) begin
      if (s_bvalid && s_bready) b_cnt <= b_cnt + 1;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [31:0] a, input logic [15:0] d, input logic [1:0] s);
      s_awvalid = 1'b1;
      s_awaddr  = a;
      s_wvalid  = 1'b1;
      s_wdata   = d;
      s_wstrb   = s;
   endtask

   task automatic drop();
      s_awvalid = 1'b0;
      s_wvalid  = 1'b0;
   endtask

   task automatic wait_b(input string tag, input int max);
      for (int i = 0; i < max && !s_bvalid; i++) @(negedge clk);
      check(tag, 64'(s_bvalid), 64'd1);
   endtask

   int b0;

   initial begin
      rst = 1'b1;
      s_awvalid = 1'b0; s_awaddr = 32'h0; s_wvalid = 1'b0; s_wdata = 16'h0;
      s_wstrb = 2'b00; s_bready = 1'b1;
      m_awready = 2'b11; m_wready = 2'b11;
      m_bresp[0] = 2'b10; m_bresp[1] = 2'b00;
      b_en = 1'b1;
      c_awvalid = 1'b0; c_awaddr = 32'h0; c_wvalid = 1'b0; c_wdata = 16'h0;
      c_wstrb = 2'b00; c_bready = 1'b1;
      c_m_awready = 3'b111; c_m_wready = 3'b111; c_m_bvalid = 3'b001;
      c_m_bresp = '0;
      repeat (3) @(negedge clk);

      // Reset values
      check("rst_awready", 64'(s_awready), 64'd1);
      check("rst_wready",  64'(s_wready),  64'd1);
      check("rst_bvalid",  64'(s_bvalid),  64'd0);
      check("rst_m_valid", 64'({m_awvalid, m_wvalid}), 64'd0);
      check("rst_m_bready", 64'(m_bready), 64'd0);
      check("rst3_m_bready", 64'(c_m_bready), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // T1: AW+W together to sub1, OKAY response
      send(32'h8000_0010, 16'hBEEF, 2'b11);
      @(negedge clk); drop();
      check("t1_awvalid", 64'(m_awvalid), 64'h2);
      check("t1_wvalid",  64'(m_wvalid),  64'h2);
      check("t1_awaddr",  64'(m_awaddr[1]), 64'h10);
      check("t1_wdata",   64'(m_wdata[1]),  64'hBEEF);
      @(negedge clk);
      check("t1_m_bready", 64'(m_bready), 64'h2);
      check("t1_no_b_yet", 64'(s_bvalid), 64'd0);
      @(negedge clk);
      check("t1_bvalid", 64'(s_bvalid), 64'd1);
      check("t1_bresp",  64'(s_bresp),  64'd0);
      @(negedge clk);

      // T2: W leads AW by 5 cycles, sub0 answers SLVERR
      s_wvalid = 1'b1; s_wdata = 16'h1234; s_wstrb = 2'b01;
      @(negedge clk); s_wvalid = 1'b0;
      check("t2_wready_held", 64'(s_wready), 64'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t2_wait", 64'({m_awvalid, m_wvalid, s_wready}), 64'd0);
      end
      s_awvalid = 1'b1; s_awaddr = 32'h0000_0004;
      check("t2_awready", 64'(s_awready), 64'd1);
      @(negedge clk); s_awvalid = 1'b0;
      check("t2_valids", 64'({m_awvalid, m_wvalid}), 64'h5);
      check("t2_awaddr", 64'(m_awaddr[0]), 64'h4);
      check("t2_wdata",  64'(m_wdata[0]),  64'h1234);
      check("t2_wstrb",  64'(m_wstrb[0]),  64'h1);
      check("t2_wready_free", 64'(s_wready), 64'd1);
      wait_b("t2_b", 10);
      check("t2_bresp", 64'(s_bresp), 64'h2);
      @(negedge clk);

      // T4: sub1 stalls awready for 3 cycles, wready immediate
      m_awready[1] = 1'b0;
      send(32'h8000_0020, 16'h5A5A, 2'b11);
      @(negedge clk); drop();
      check("t4_start",  64'({m_awvalid, m_wvalid}), 64'hA);
      @(negedge clk);
      check("t4_w_drop", 64'({m_awvalid, m_wvalid}), 64'h8);
      @(negedge clk);
      check("t4_aw_hold1", 64'(m_awvalid), 64'h2);
      @(negedge clk);
      check("t4_aw_hold2", 64'(m_awvalid), 64'h2);
      m_awready[1] = 1'b1;
      @(negedge clk);
      check("t4_aw_drop", 64'(m_awvalid), 64'h0);
      b0 = b_cnt;
      wait_b("t4_b", 10);
      check("t4_bresp", 64'(s_bresp), 64'd0);
      repeat (4) @(negedge clk);
      check("t4_one_b", 64'(b_cnt - b0), 64'd1);

      // T5: manager stalls B for 10 cycles with a second write queued
      s_bready = 1'b0;
      send(32'h0000_0040, 16'hAAAA, 2'b11);
      @(negedge clk); drop();
      wait_b("t5_b1", 10);
      send(32'h8000_0050, 16'h5555, 2'b10);
      check("t5_awready", 64'(s_awready), 64'd1);
      @(negedge clk); drop();
      for (int i = 0; i < 10; i++) begin
         check("t5_hold", 64'({s_bvalid, s_bresp, m_awvalid}), 64'({1'b1, 2'b10, 2'b00}));
         @(negedge clk);
      end
      s_bready = 1'b1;
      @(negedge clk);
      check("t5_next", 64'({s_bvalid, m_awvalid}), 64'({1'b0, 2'b10}));
      wait_b("t5_b2", 10);
      check("t5_bresp2", 64'(s_bresp), 64'd0);
      check("t5_addr2", 64'(m_awaddr[1]), 64'h50);
      @(negedge clk);

      // T6: reset while waiting in RESP, then a zero-strobe write to sub0
      b_en = 1'b0;
      send(32'h8000_0060, 16'h7777, 2'b11);
      @(negedge clk); drop();
      @(negedge clk);
      @(negedge clk);
      check("t6_in_resp", 64'(m_bready), 64'h2);
      rst = 1'b1;
      @(negedge clk);
      check("t6_rst", 64'({s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid, m_bready}),
            64'h180);
      rst = 1'b0; b_en = 1'b1;
      @(negedge clk);
      send(32'h0000_0008, 16'h0F0F, 2'b00);
      @(negedge clk); drop();
      check("t6_awvalid", 64'(m_awvalid), 64'h1);
      check("t6_awaddr",  64'(m_awaddr[0]), 64'h8);
      check("t6_wstrb",   64'(m_wstrb[0]), 64'h0);
      wait_b("t6_b", 10);
      check("t6_bresp", 64'(s_bresp), 64'h2);
      @(negedge clk);

      // T3: NUM_S=3, select 3 decodes to nothing -> DECERR at N+2
      c_awvalid = 1'b1; c_awaddr = 32'hC000_0000;
      c_wvalid = 1'b1; c_wdata = 16'hDEAD; c_wstrb = 2'b11;
      @(negedge clk); c_awvalid = 1'b0; c_wvalid = 1'b0;
      check("t3_err_n1", 64'({c_m_awvalid, c_m_wvalid, c_bvalid}), 64'd0);
      @(negedge clk);
      check("t3_err_b", 64'({c_bvalid, c_bresp}), 64'h7);
      check("t3_err_m", 64'({c_m_awvalid, c_m_wvalid}), 64'd0);
      @(negedge clk);
      // Select 2 is routed; stray bvalid from sub0 must never be accepted
      c_awvalid = 1'b1; c_awaddr = 32'h8000_0004; c_wvalid = 1'b1;
      @(negedge clk); c_awvalid = 1'b0; c_wvalid = 1'b0;
      check("t3_sel2",  64'(c_m_awvalid), 64'h4);
      check("t3_addr2", 64'(c_m_awaddr[2]), 64'h4);
      @(negedge clk);
      check("t3_bready_sel", 64'(c_m_bready), 64'h4);
      check("t3_no_b", 64'(c_bvalid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
